// File: rtl/cpu_mem_fsm.sv
// cpu_mem_fsm
// Multi-cycle load/store unit for the MEM stage. A request is latched in
// IDLE, presented on a registered bus handshake in WAIT until bus_ack, and
// written back for exactly one cycle in DONE. It also holds the LL bit used by
// LL/SC, raises address errors for misaligned accesses, and fails an SC
// without touching the bus when the LL bit is clear.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/we/size/signed  memory operation from EX/MEM
//   req_ll/req_sc             LL / SC qualifiers
//   req_addr, req_wdata       byte address, right-aligned store data
//   req_rd                    destination register for loads and SC
//   flush                     pipeline flush, also clears the LL bit
//   bus_req/we/addr/be/wdata  data bus request, held until bus_ack
//   bus_rdata, bus_ack        read data and transfer-complete strobe
//   stall_req                 holds upstream stages while busy
//   wb_we/waddr/wdata         register writeback
//   except_occur/code/badvaddr address error (4 = AdEL, 5 = AdES)
//   llbit                     current LL bit

module cpu_mem_fsm #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit CHECK_ALIGN    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic                      req_ll,
  input  logic                      req_sc,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [31:0]               req_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd,
  input  logic                      flush,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [ADDR_WIDTH-1:0]     bus_addr,
  output logic [3:0]                bus_be,
  output logic [31:0]               bus_wdata,
  input  logic [31:0]               bus_rdata,
  input  logic                      bus_ack,
  output logic                      stall_req,
  output logic                      wb_we,
  output logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  output logic [31:0]               wb_wdata,
  output logic                      except_occur,
  output logic [4:0]                except_code,
  output logic [ADDR_WIDTH-1:0]     except_badvaddr,
  output logic                      llbit
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      llBit_q, llBit_d;
  logic                      drop_q, drop_d;

  // Fields of the accepted request, held for the whole WAIT/DONE sequence.
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [1:0]                size_q;
  logic                      signed_q;
  logic                      ll_q;
  logic                      sc_q;
  logic                      we_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [31:0]               wdata_q;
  logic [31:0]               rdata_q;

  logic                      reqIsStore;
  logic                      reqIsHalf;
  logic                      reqIsWord;
  logic                      misaligned;
  logic                      addrErr;
  logic                      idleValid;
  logic                      raiseExc;
  logic                      scFail;
  logic                      accept;
  logic [ADDR_WIDTH-1:0]     alignedAddr;

  logic [1:0]                lane;
  logic [31:0]               loadShifted;
  logic [31:0]               loadData;
  logic [3:0]                latchedBe;
  logic [31:0]               latchedWdata;

  // Request decode in IDLE. An SC counts as a store for the exception code.
  // A flushed instruction is neither accepted nor allowed to fault. The
  // aligned address is what gets latched, so with alignment checking off the
  // low bits are simply forced to the natural boundary of the access size.
  always_comb begin
    reqIsStore  = req_we | req_sc;
    reqIsHalf   = (req_size == 2'd1);
    reqIsWord   = req_size[1];
    misaligned  = (reqIsHalf & req_addr[0]) |
                  (reqIsWord & (req_addr[1:0] != 2'b00));
    addrErr     = CHECK_ALIGN & misaligned;
    idleValid   = (state_q == ST_IDLE) & req_valid & ~flush;
    raiseExc    = idleValid & addrErr;
    scFail      = idleValid & ~addrErr & req_sc & ~llBit_q;
    accept      = idleValid & ~addrErr & ~scFail;

    alignedAddr = req_addr;
    if (reqIsHalf) begin
      alignedAddr[0] = 1'b0;
    end
    if (reqIsWord) begin
      alignedAddr[1:0] = 2'b00;
    end
  end

  // Byte-lane steering from the latched request: enables and replicated
  // store data for the bus, and the shifted/extended load result.
  always_comb begin
    lane        = addr_q[1:0];
    loadShifted = rdata_q >> {lane, 3'b000};

    if (size_q[1]) begin
      latchedBe    = 4'b1111;
      latchedWdata = wdata_q;
      loadData     = rdata_q;
    end else if (size_q == 2'd1) begin
      latchedBe    = 4'b0011 << lane;
      latchedWdata = {2{wdata_q[15:0]}};
      loadData     = {{16{signed_q & loadShifted[15]}}, loadShifted[15:0]};
    end else begin
      latchedBe    = 4'b0001 << lane;
      latchedWdata = {4{wdata_q[7:0]}};
      loadData     = {{24{signed_q & loadShifted[7]}}, loadShifted[7:0]};
    end
  end

  // Next-state and LL bit. A flush seen in WAIT only marks the transfer as
  // dropped: the bus cycle must still complete, after which we return straight
  // to IDLE with no writeback and without arming the LL bit. Flush is applied
  // last so that it beats a same-cycle LL set.
  always_comb begin
    state_d = state_q;
    llBit_d = llBit_q;
    drop_d  = drop_q;

    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (accept) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          drop_d = 1'b1;
        end
        if (bus_ack) begin
          if (drop_q | flush) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            if (ll_q) begin
              llBit_d = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        drop_d  = 1'b0;
        if (sc_q) begin
          llBit_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        drop_d  = 1'b0;
      end
    endcase

    if (flush) begin
      llBit_d = 1'b0;
    end
  end

  // State, LL bit and request latches. Read data is captured only on an ack
  // that arrives in WAIT; acks at any other time are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      llBit_q  <= 1'b0;
      drop_q   <= 1'b0;
      addr_q   <= '0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      ll_q     <= 1'b0;
      sc_q     <= 1'b0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      llBit_q <= llBit_d;
      drop_q  <= drop_d;
      if (accept) begin
        addr_q   <= alignedAddr;
        size_q   <= req_size;
        signed_q <= req_signed;
        ll_q     <= req_ll;
        sc_q     <= req_sc;
        we_q     <= reqIsStore;
        rd_q     <= req_rd;
        wdata_q  <= req_wdata;
      end
      if ((state_q == ST_WAIT) && bus_ack) begin
        rdata_q <= bus_rdata;
      end
    end
  end

  // Outputs. IDLE drives only the same-cycle responses (address error,
  // failed SC, stall on accept). WAIT presents the latched request on the
  // bus. DONE writes back once unless flushed.
  always_comb begin
    bus_req         = 1'b0;
    bus_we          = 1'b0;
    bus_addr        = '0;
    bus_be          = 4'b0000;
    bus_wdata       = 32'd0;
    stall_req       = 1'b0;
    wb_we           = 1'b0;
    wb_waddr        = '0;
    wb_wdata        = 32'd0;
    except_occur    = 1'b0;
    except_code     = 5'd0;
    except_badvaddr = '0;

    case (state_q)
      ST_IDLE: begin
        if (raiseExc) begin
          except_occur    = 1'b1;
          except_code     = reqIsStore ? 5'd5 : 5'd4;
          except_badvaddr = req_addr;
        end
        if (scFail) begin
          wb_we    = 1'b1;
          wb_waddr = req_rd;
          wb_wdata = 32'd0;
        end
        stall_req = accept;
      end
      ST_WAIT: begin
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus_be    = latchedBe;
        bus_wdata = latchedWdata;
        stall_req = 1'b1;
      end
      ST_DONE: begin
        if (!flush) begin
          if (sc_q) begin
            wb_we    = 1'b1;
            wb_waddr = rd_q;
            wb_wdata = 32'd1;
          end else if (!we_q) begin
            wb_we    = 1'b1;
            wb_waddr = rd_q;
            wb_wdata = loadData;
          end
        end
      end
      default: begin
        stall_req = 1'b0;
      end
    endcase
  end

  assign llbit = llBit_q;

endmodule

// File: tb/tb_cpu_mem_fsm.sv
// tb_cpu_mem_fsm
// Testbench for cpu_mem_fsm: directed cases for sized loads/stores, address
// errors, LL/SC, flush and reset in WAIT, plus randomized plain loads and
// stores compared against an arithmetic byte-lane model.

module tb_cpu_mem_fsm;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        req_ll;
  logic        req_sc;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        flush;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stall_req;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        except_occur;
  logic [4:0]  except_code;
  logic [31:0] except_badvaddr;
  logic        llbit;

  int total;
  int bad;

  // Observations recorded by applyStimulus for one transaction.
  logic        obsIdleStall;
  logic        obsExc;
  logic [4:0]  obsCode;
  logic [31:0] obsBadv;
  logic        obsIdleWbWe;
  logic [4:0]  obsIdleWbAddr;
  logic [31:0] obsIdleWbData;
  int          obsStallCycles;
  int          obsBusReqCycles;
  logic        obsBusUnstable;
  logic [3:0]  obsBe;
  logic [31:0] obsBusAddr;
  logic [31:0] obsBusWdata;
  logic        obsBusWe;
  logic        obsDoneStall;
  logic        obsWbWe;
  logic [4:0]  obsWbAddr;
  logic [31:0] obsWbData;
  logic        obsAfterStall;
  logic        obsLl;

  cpu_mem_fsm #(
    .ADDR_WIDTH(32),
    .REG_ADDR_WIDTH(5),
    .CHECK_ALIGN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_we(req_we),
    .req_size(req_size),
    .req_signed(req_signed),
    .req_ll(req_ll),
    .req_sc(req_sc),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_rd(req_rd),
    .flush(flush),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_be(bus_be),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack(bus_ack),
    .stall_req(stall_req),
    .wb_we(wb_we),
    .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata),
    .except_occur(except_occur),
    .except_code(except_code),
    .except_badvaddr(except_badvaddr),
    .llbit(llbit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: access size in bytes.
  function automatic int modelBytes(input logic [1:0] size);
    if (size == 2'd0) return 1;
    if (size == 2'd1) return 2;
    return 4;
  endfunction

  // Reference model: byte enables are the lanes covered by the access.
  function automatic logic [3:0] modelBe(input logic [31:0] addr, input logic [1:0] size);
    logic [3:0] be;
    int first;
    int n;
    be    = 4'b0000;
    first = int'(addr % 4);
    n     = modelBytes(size);
    for (int i = 0; i < 4; i++) begin
      if (i >= first && i < first + n) be[i] = 1'b1;
    end
    return be;
  endfunction

  // Reference model: narrow store data copied into every lane by multiplication.
  function automatic logic [31:0] modelWdata(input logic [31:0] w, input logic [1:0] size);
    longint v;
    if (modelBytes(size) == 1) v = longint'(w % 256) * 64'h0101_0101;
    else if (modelBytes(size) == 2) v = longint'(w % 65536) * 64'h0001_0001;
    else v = longint'(w);
    return v[31:0];
  endfunction

  // Reference model: pick the addressed bytes out of the word, then extend.
  function automatic logic [31:0] modelLoad(input logic [31:0] rdata, input logic [31:0] addr,
                                            input logic [1:0] size, input logic sgn);
    longint v;
    longint span;
    int n;
    n = modelBytes(size);
    if (n == 4) return rdata;
    span = longint'(1) << (8 * n);
    v = (longint'(rdata) / (longint'(1) << (8 * int'(addr % 4)))) % span;
    if (sgn && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic idleInputs();
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_ll     = 1'b0;
    req_sc     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_rd     = 5'd0;
    flush      = 1'b0;
    bus_ack    = 1'b0;
  endtask

  // Presents one request, acks on the nWait-th bus cycle, and records what
  // the design did in the request, bus, writeback and following idle cycles.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic ll, input logic sc, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd,
                               input logic [31:0] rdata, input int nWait);
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_ll     = ll;
    req_sc     = sc;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    flush      = 1'b0;
    bus_ack    = 1'b0;
    bus_rdata  = $urandom;
    @(negedge clk);
    obsIdleStall    = stall_req;
    obsExc          = except_occur;
    obsCode         = except_code;
    obsBadv         = except_badvaddr;
    obsIdleWbWe     = wb_we;
    obsIdleWbAddr   = wb_waddr;
    obsIdleWbData   = wb_wdata;
    obsStallCycles  = stall_req ? 1 : 0;
    obsBusReqCycles = bus_req ? 1 : 0;
    obsBusUnstable  = 1'b0;
    obsBe           = 4'b0000;
    obsBusAddr      = 32'd0;
    obsBusWdata     = 32'd0;
    obsBusWe        = 1'b0;
    obsDoneStall    = 1'b0;
    obsWbWe         = 1'b0;
    obsWbAddr       = 5'd0;
    obsWbData       = 32'd0;
    if (!stall_req) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      if (bus_req) obsBusReqCycles++;
      obsAfterStall = stall_req;
      obsLl         = llbit;
      return;
    end
    for (int k = 0; k < nWait; k++) begin
      @(posedge clk); #1;
      bus_ack   = (k == nWait - 1);
      bus_rdata = (k == nWait - 1) ? rdata : $urandom;
      @(negedge clk);
      if (stall_req) obsStallCycles++;
      if (bus_req) obsBusReqCycles++;
      if (k == 0) begin
        obsBe       = bus_be;
        obsBusAddr  = bus_addr;
        obsBusWdata = bus_wdata;
        obsBusWe    = bus_we;
      end else if (bus_be != obsBe || bus_addr != obsBusAddr ||
                   bus_wdata != obsBusWdata || bus_we != obsBusWe) begin
        obsBusUnstable = 1'b1;
      end
    end
    @(posedge clk); #1;
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    @(negedge clk);
    obsDoneStall = stall_req;
    obsWbWe      = wb_we;
    obsWbAddr    = wb_waddr;
    obsWbData    = wb_wdata;
    if (bus_req) obsBusReqCycles++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    obsAfterStall = stall_req;
    obsLl         = llbit;
    if (bus_req) obsBusReqCycles++;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== 70'd0) begin
      bad++;
      $display("[TB] FAIL reset_bus: got req=%b we=%b be=%b addr=%h wdata=%h want all 0",
               bus_req, bus_we, bus_be, bus_addr, bus_wdata);
    end
    total++;
    if ({wb_we, wb_waddr, wb_wdata} !== 38'd0) begin
      bad++;
      $display("[TB] FAIL reset_wb: got we=%b addr=%h data=%h want all 0", wb_we, wb_waddr, wb_wdata);
    end
    total++;
    if ({except_occur, except_code, except_badvaddr} !== 38'd0) begin
      bad++;
      $display("[TB] FAIL reset_exc: got occur=%b code=%h badv=%h want all 0",
               except_occur, except_code, except_badvaddr);
    end
    total++;
    if ({stall_req, llbit} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_stall_ll: got stall=%b ll=%b want 0 0", stall_req, llbit);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    $display("[TB] test_directed");
    // Signed byte load from the top lane, two bus cycles.
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0000_1003, 32'd0, 5'd1, 32'h80FF_0000, 2);
    total++;
    if (obsBe !== 4'b1000) begin bad++; $display("[TB] FAIL lb_be: got %b want 1000", obsBe); end
    total++;
    if (obsBusAddr !== 32'h0000_1000) begin bad++; $display("[TB] FAIL lb_addr: got %h want 00001000", obsBusAddr); end
    total++;
    if (obsStallCycles !== 3) begin bad++; $display("[TB] FAIL lb_stall: got %0d want 3", obsStallCycles); end
    total++;
    if ({obsWbWe, obsWbAddr, obsWbData} !== {1'b1, 5'd1, 32'hFFFF_FF80}) begin
      bad++;
      $display("[TB] FAIL lb_wb: got we=%b rd=%0d data=%h want 1 1 ffffff80", obsWbWe, obsWbAddr, obsWbData);
    end
    total++;
    if (obsDoneStall !== 1'b0) begin bad++; $display("[TB] FAIL lb_done_stall: got %b want 0", obsDoneStall); end

    // Unsigned half load from the upper half, immediate ack.
    applyStimulus(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 32'h0000_2002, 32'd0, 5'd2, 32'hBEEF_1234, 1);
    total++;
    if (obsBe !== 4'b1100) begin bad++; $display("[TB] FAIL lhu_be: got %b want 1100", obsBe); end
    total++;
    if (obsStallCycles !== 2) begin bad++; $display("[TB] FAIL lhu_stall: got %0d want 2", obsStallCycles); end
    total++;
    if (obsWbData !== 32'h0000_BEEF) begin bad++; $display("[TB] FAIL lhu_data: got %h want 0000beef", obsWbData); end

    // Half store, replicated into both halves, no writeback.
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h0000_3002, 32'h0000_ABCD, 5'd3, 32'd0, 1);
    total++;
    if ({obsBusWe, obsBe} !== 5'b1_1100) begin
      bad++;
      $display("[TB] FAIL sh_we_be: got we=%b be=%b want 1 1100", obsBusWe, obsBe);
    end
    total++;
    if (obsBusWdata !== 32'hABCD_ABCD) begin bad++; $display("[TB] FAIL sh_wdata: got %h want abcdabcd", obsBusWdata); end
    total++;
    if (obsWbWe !== 1'b0) begin bad++; $display("[TB] FAIL sh_wb_we: got %b want 0", obsWbWe); end
  endtask

  task automatic test_misaligned();
    $display("[TB] test_misaligned");
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0000_4001, 32'd0, 5'd6, 32'd0, 1);
    total++;
    if ({obsExc, obsCode, obsBadv} !== {1'b1, 5'd4, 32'h0000_4001}) begin
      bad++;
      $display("[TB] FAIL lw_exc: got occur=%b code=%0d badv=%h want 1 4 00004001", obsExc, obsCode, obsBadv);
    end
    total++;
    if ({obsIdleStall, obsIdleWbWe} !== 2'b00 || obsBusReqCycles !== 0) begin
      bad++;
      $display("[TB] FAIL lw_exc_side: got stall=%b wb=%b busreq=%0d want 0 0 0",
               obsIdleStall, obsIdleWbWe, obsBusReqCycles);
    end
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0000_4001, 32'h1234_5678, 5'd6, 32'd0, 1);
    total++;
    if ({obsExc, obsCode} !== {1'b1, 5'd5}) begin
      bad++;
      $display("[TB] FAIL sw_exc: got occur=%b code=%0d want 1 5", obsExc, obsCode);
    end
    total++;
    if (obsBusReqCycles !== 0) begin bad++; $display("[TB] FAIL sw_busreq: got %0d want 0", obsBusReqCycles); end
  endtask

  task automatic test_llsc();
    logic [31:0] r;
    $display("[TB] test_llsc");
    r = $urandom;
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0000_5000, 32'd0, 5'd3, r, 2);
    total++;
    if ({obsWbWe, obsWbData, obsLl} !== {1'b1, r, 1'b1}) begin
      bad++;
      $display("[TB] FAIL ll: got wb=%b data=%h ll=%b want 1 %h 1", obsWbWe, obsWbData, obsLl, r);
    end
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h0000_5000, 32'hCAFE_0001, 5'd4, 32'd0, 1);
    total++;
    if ({obsBusWe, obsBusReqCycles[3:0]} !== {1'b1, 4'd1}) begin
      bad++;
      $display("[TB] FAIL sc_bus: got we=%b busreq=%0d want 1 1", obsBusWe, obsBusReqCycles);
    end
    total++;
    if ({obsWbWe, obsWbAddr, obsWbData, obsLl} !== {1'b1, 5'd4, 32'd1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL sc_ok: got wb=%b rd=%0d data=%h ll=%b want 1 4 1 0", obsWbWe, obsWbAddr, obsWbData, obsLl);
    end
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h0000_5000, 32'hCAFE_0002, 5'd5, 32'd0, 1);
    total++;
    if ({obsIdleStall, obsIdleWbWe, obsIdleWbAddr, obsIdleWbData} !== {1'b0, 1'b1, 5'd5, 32'd0} ||
        obsBusReqCycles !== 0) begin
      bad++;
      $display("[TB] FAIL sc_fail: got stall=%b wb=%b rd=%0d data=%h busreq=%0d want 0 1 5 0 0",
               obsIdleStall, obsIdleWbWe, obsIdleWbAddr, obsIdleWbData, obsBusReqCycles);
    end
    // LL, a flush, then SC: the flush must have discarded the reservation.
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0000_5000, 32'd0, 5'd3, 32'd7, 1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    total++;
    if (llbit !== 1'b0) begin bad++; $display("[TB] FAIL flush_ll: got %b want 0", llbit); end
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h0000_5000, 32'd9, 5'd8, 32'd0, 1);
    total++;
    if ({obsIdleWbWe, obsIdleWbData} !== {1'b1, 32'd0} || obsBusReqCycles !== 0) begin
      bad++;
      $display("[TB] FAIL sc_after_flush: got wb=%b data=%h busreq=%0d want 1 0 0",
               obsIdleWbWe, obsIdleWbData, obsBusReqCycles);
    end
  endtask

  task automatic test_flush_wait();
    int  busCycles;
    logic sawWb;
    $display("[TB] test_flush_wait");
    busCycles = 0;
    sawWb     = 1'b0;
    @(posedge clk); #1;
    idleInputs();
    req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h0000_6000; req_rd = 5'd7;
    @(negedge clk);
    total++;
    if (stall_req !== 1'b1) begin bad++; $display("[TB] FAIL fl_accept: got %b want 1", stall_req); end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      flush     = (c == 0);
      bus_ack   = (c == 3);
      bus_rdata = $urandom;
      @(negedge clk);
      if (c <= 3 && bus_req) busCycles++;
      if (wb_we) sawWb = 1'b1;
      if (c == 4) begin
        total++;
        if ({bus_req, stall_req} !== 2'b00) begin
          bad++;
          $display("[TB] FAIL fl_idle: got req=%b stall=%b want 0 0", bus_req, stall_req);
        end
      end
    end
    total++;
    if (busCycles !== 4) begin bad++; $display("[TB] FAIL fl_bus_kept: got %0d want 4", busCycles); end
    total++;
    if (sawWb !== 1'b0) begin bad++; $display("[TB] FAIL fl_no_wb: got %b want 0", sawWb); end
    bus_ack = 1'b0;
  endtask

  task automatic test_reset_wait();
    $display("[TB] test_reset_wait");
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0000_5100, 32'd0, 5'd2, 32'd1, 1);
    total++;
    if (obsLl !== 1'b1) begin bad++; $display("[TB] FAIL rw_ll_set: got %b want 1", obsLl); end
    @(posedge clk); #1;
    idleInputs();
    req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h0000_7000; req_rd = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus_req !== 1'b1) begin bad++; $display("[TB] FAIL rw_wait: got %b want 1", bus_req); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, stall_req, wb_we, wb_waddr, wb_wdata,
         except_occur, llbit} !== 111'd0) begin
      bad++;
      $display("[TB] FAIL rw_outputs: got req=%b stall=%b wb=%b ll=%b exc=%b want all 0",
               bus_req, stall_req, wb_we, llbit, except_occur);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({bus_req, stall_req, wb_we} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL rw_ack_ignored: got req=%b stall=%b wb=%b want 0 0 0", bus_req, stall_req, wb_we);
    end
  endtask

  task automatic test_random();
    logic        we;
    logic        sgn;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd32;
    logic [4:0]  rd;
    int          nWait;
    int          n;
    $display("[TB] test_random");
    for (int it = 0; it < 40; it++) begin
      we    = 1'($urandom_range(0, 1));
      sgn   = 1'($urandom_range(0, 1));
      sz    = 2'($urandom_range(0, 3));
      addr  = $urandom;
      wd    = $urandom;
      rd32  = $urandom;
      rd    = 5'($urandom);
      nWait = $urandom_range(1, 4);
      n     = modelBytes(sz);
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % n);
      applyStimulus(we, sz, sgn, 1'b0, 1'b0, addr, wd, rd, rd32, nWait);
      if ((addr % n) != 0) begin
        total++;
        if ({obsExc, obsCode, obsBadv} !== {1'b1, (we ? 5'd5 : 5'd4), addr} || obsBusReqCycles !== 0) begin
          bad++;
          $display("[TB] FAIL rnd_exc: got occur=%b code=%0d badv=%h busreq=%0d want 1 %0d %h 0",
                   obsExc, obsCode, obsBadv, obsBusReqCycles, we ? 5 : 4, addr);
        end
      end else begin
        total++;
        if (obsStallCycles !== 1 + nWait || obsBusReqCycles !== nWait || obsDoneStall !== 1'b0 ||
            obsAfterStall !== 1'b0) begin
          bad++;
          $display("[TB] FAIL rnd_timing: got stall=%0d busreq=%0d want %0d %0d",
                   obsStallCycles, obsBusReqCycles, 1 + nWait, nWait);
        end
        total++;
        if ({obsBe, obsBusAddr, obsBusWe, obsBusUnstable} !==
            {modelBe(addr, sz), addr - (addr % 4), we, 1'b0}) begin
          bad++;
          $display("[TB] FAIL rnd_bus: got be=%b addr=%h we=%b unstable=%b want %b %h %b 0",
                   obsBe, obsBusAddr, obsBusWe, obsBusUnstable, modelBe(addr, sz), addr - (addr % 4), we);
        end
        if (we) begin
          total++;
          if ({obsBusWdata, obsWbWe} !== {modelWdata(wd, sz), 1'b0}) begin
            bad++;
            $display("[TB] FAIL rnd_store: got wdata=%h wb=%b want %h 0", obsBusWdata, obsWbWe, modelWdata(wd, sz));
          end
        end else begin
          total++;
          if ({obsWbWe, obsWbAddr, obsWbData} !== {1'b1, rd, modelLoad(rd32, addr, sz, sgn)}) begin
            bad++;
            $display("[TB] FAIL rnd_load: got wb=%b rd=%0d data=%h want 1 %0d %h",
                     obsWbWe, obsWbAddr, obsWbData, rd, modelLoad(rd32, addr, sz, sgn));
          end
        end
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus_rdata = 32'd0;
    idleInputs();
    test_reset();
    test_directed();
    test_misaligned();
    test_llsc();
    test_flush_wait();
    test_reset_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
